// File: rtl/instr_decode_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | instr_decode_reg: decode-stage register with one-entry skid buffer.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module instr_decode_reg #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        if_valid,
  output logic        if_ready,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [2:0]  id_imm_type,
  output logic [4:0]  id_rd,
  output logic [4:0]  id_rs1,
  output logic [4:0]  id_rs2,
  output logic        id_illegal
);

  localparam logic [6:0] c_OP_IMM = 7'b0010011;
  localparam logic [6:0] c_LOAD   = 7'b0000011;
  localparam logic [6:0] c_JALR   = 7'b1100111;
  localparam logic [6:0] c_STORE  = 7'b0100011;
  localparam logic [6:0] c_BRANCH = 7'b1100011;
  localparam logic [6:0] c_LUI    = 7'b0110111;
  localparam logic [6:0] c_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_JAL    = 7'b1101111;
  localparam logic [6:0] c_SYSTEM = 7'b1110011;
  localparam logic [6:0] c_OP     = 7'b0110011;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [2:0]  imm_type;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        illegal;
  } entry_t;

  function automatic entry_t decode(input logic [31:0] instr, input logic [31:0] pc);
    entry_t e;
    e.instr   = instr;
    e.pc      = pc;
    e.rd      = instr[11:7];
    e.rs1     = instr[19:15];
    e.rs2     = instr[24:20];
    e.illegal = 1'b0;
    case (instr[6:0])
      c_OP_IMM, c_LOAD, c_JALR, c_OP: e.imm_type = 3'b000;
      c_STORE:                        e.imm_type = 3'b001;
      c_BRANCH:                       e.imm_type = 3'b010;
      c_LUI, c_AUIPC:                 e.imm_type = 3'b011;
      c_JAL:                          e.imm_type = 3'b100;
      // CSR immediate forms (funct3[2]=1) use the zimm format
      c_SYSTEM:                       e.imm_type = instr[14] ? 3'b101 : 3'b000;
      default: begin
        e.imm_type = 3'b111;
        e.illegal  = 1'b1;
      end
    endcase
    return e;
  endfunction

  function automatic entry_t bubble(input logic [31:0] pc);
    entry_t e;
    e          = '0;
    e.instr    = NOP_INSTR;
    e.pc       = pc;
    return e;
  endfunction

  entry_t out_q, out_d, skid_q, skid_d;
  logic   out_v_q, out_v_d, skid_v_q, skid_v_d;
  logic   in_xfer, out_xfer, out_free;

  assign if_ready = !skid_v_q;
  assign in_xfer  = if_valid && if_ready;
  assign out_xfer = out_v_q && id_ready;
  assign out_free = !out_v_q || out_xfer;

  always_comb begin
    out_d    = out_q;
    out_v_d  = out_v_q;
    skid_d   = skid_q;
    skid_v_d = skid_v_q;
    if (flush) begin
      out_d    = bubble(out_q.pc);
      out_v_d  = 1'b0;
      skid_v_d = 1'b0;
    end else if (out_free) begin
      if (skid_v_q) begin
        out_d    = skid_q;
        out_v_d  = 1'b1;
        skid_v_d = 1'b0;
      end else if (in_xfer) begin
        out_d   = decode(if_instr, if_pc);
        out_v_d = 1'b1;
      end else begin
        out_d   = bubble(out_q.pc);
        out_v_d = 1'b0;
      end
    end else if (in_xfer) begin
      skid_d   = decode(if_instr, if_pc);
      skid_v_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q    <= bubble(32'h0);
      out_v_q  <= 1'b0;
      skid_q   <= bubble(32'h0);
      skid_v_q <= 1'b0;
    end else begin
      out_q    <= out_d;
      out_v_q  <= out_v_d;
      skid_q   <= skid_d;
      skid_v_q <= skid_v_d;
    end
  end

  assign id_valid    = out_v_q;
  assign id_instr    = out_q.instr;
  assign id_pc       = out_q.pc;
  assign id_imm_type = out_q.imm_type;
  assign id_rd       = out_q.rd;
  assign id_rs1      = out_q.rs1;
  assign id_rs2      = out_q.rs2;
  assign id_illegal  = out_q.illegal;

endmodule
`default_nettype wire

// File: tb/tb_instr_decode_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_instr_decode_reg: directed and random handshake bench for the decoder.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_instr_decode_reg;

  logic        clk = 1'b0;
  logic        rst, flush, if_valid, if_ready, id_valid, id_ready, id_illegal;
  logic [31:0] if_instr, if_pc, id_instr, id_pc;
  logic [2:0]  id_imm_type;
  logic [4:0]  id_rd, id_rs1, id_rs2;

  int n_checks = 0;
  int n_fail   = 0;

  instr_decode_reg #(.NOP_INSTR(32'h0000_0013)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
    .id_imm_type(id_imm_type), .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_illegal(id_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] instr, input logic [31:0] pc);
    if_valid = 1'b1;
    if_instr = instr;
    if_pc    = pc;
  endtask

  logic [31:0] sweep_instr [6] = '{32'h12345037, 32'h00001097, 32'h008000EF,
                                   32'h3400D073, 32'h34011073, 32'h0000000B};
  logic [2:0]  sweep_imm   [6] = '{3'd3, 3'd3, 3'd4, 3'd5, 3'd0, 3'd7};
  logic        sweep_ill   [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  logic [63:0] sb[$];
  logic [63:0] exp_e;
  logic [31:0] seq, hold_instr, hold_pc;
  logic        in_acc, out_acc, stall;

  initial begin
    rst = 1'b1; flush = 1'b0; if_valid = 1'b0; id_ready = 1'b0;
    if_instr = '0; if_pc = '0;
    step(); step();
    rst = 1'b0;
    chk("rst_id_valid", {31'b0, id_valid}, 32'd0);
    chk("rst_if_ready", {31'b0, if_ready}, 32'd1);
    chk("rst_id_instr", id_instr, 32'h0000_0013);
    chk("rst_id_pc", id_pc, 32'h0);
    chk("rst_fields", {id_imm_type, id_rd, id_rs1, id_rs2, id_illegal}, 32'h0);

    // single addi, one-cycle latency
    id_ready = 1'b1;
    offer(32'h00500093, 32'h100);
    step();
    if_valid = 1'b0;
    chk("addi_valid", {31'b0, id_valid}, 32'd1);
    chk("addi_instr", id_instr, 32'h00500093);
    chk("addi_pc", id_pc, 32'h100);
    chk("addi_imm", {29'b0, id_imm_type}, 32'd0);
    chk("addi_rd", {27'b0, id_rd}, 32'd1);
    chk("addi_rs2", {27'b0, id_rs2}, 32'd5);
    step();
    chk("drain_valid", {31'b0, id_valid}, 32'd0);
    chk("drain_nop", id_instr, 32'h0000_0013);

    // stall: A in OUT, B in SKID
    id_ready = 1'b0;
    offer(32'h00112223, 32'h200);
    step();
    chk("sw_instr", id_instr, 32'h00112223);
    chk("sw_imm", {29'b0, id_imm_type}, 32'd1);
    offer(32'h00208463, 32'h204);
    step();
    if_valid = 1'b0;
    chk("skid_full_ready", {31'b0, if_ready}, 32'd0);
    chk("stall_instr", id_instr, 32'h00112223);
    chk("stall_pc", id_pc, 32'h200);
    id_ready = 1'b1;
    step();
    chk("beq_instr", id_instr, 32'h00208463);
    chk("beq_pc", id_pc, 32'h204);
    chk("beq_imm", {29'b0, id_imm_type}, 32'd2);
    chk("beq_ready", {31'b0, if_ready}, 32'd1);
    step();

    // opcode sweep, back to back
    for (int i = 0; i < 6; i++) begin
      offer(sweep_instr[i], 32'h400 + 32'(i * 4));
      step();
      chk($sformatf("sweep%0d_instr", i), id_instr, sweep_instr[i]);
      chk($sformatf("sweep%0d_imm", i), {29'b0, id_imm_type}, {29'b0, sweep_imm[i]});
      chk($sformatf("sweep%0d_ill", i), {31'b0, id_illegal}, {31'b0, sweep_ill[i]});
    end
    if_valid = 1'b0;
    step();

    // flush with both entries full and an input offered
    id_ready = 1'b0;
    offer(32'h00300113, 32'h300); step();
    offer(32'h00400193, 32'h304); step();
    offer(32'h00500213, 32'h308);
    flush = 1'b1;
    step();
    flush = 1'b0; if_valid = 1'b0;
    chk("flush_valid", {31'b0, id_valid}, 32'd0);
    chk("flush_ready", {31'b0, if_ready}, 32'd1);
    chk("flush_instr", id_instr, 32'h0000_0013);
    chk("flush_pc_held", id_pc, 32'h300);
    chk("flush_fields", {id_imm_type, id_rd, id_rs1, id_rs2, id_illegal}, 32'h0);
    id_ready = 1'b1;
    step(); step();
    chk("flush_no_ghost", {31'b0, id_valid}, 32'd0);

    // reset while SKID full
    id_ready = 1'b0;
    offer(32'h00600293, 32'h500); step();
    offer(32'h00700313, 32'h504); step();
    chk("pre_rst_full", {31'b0, if_ready}, 32'd0);
    if_valid = 1'b0;
    rst = 1'b1; flush = 1'b1;
    step();
    rst = 1'b0; flush = 1'b0;
    chk("mrst_valid", {31'b0, id_valid}, 32'd0);
    chk("mrst_ready", {31'b0, if_ready}, 32'd1);
    chk("mrst_instr", id_instr, 32'h0000_0013);
    chk("mrst_pc", id_pc, 32'h0);
    chk("mrst_fields", {id_imm_type, id_rd, id_rs1, id_rs2, id_illegal}, 32'h0);
    id_ready = 1'b1;
    offer(32'h00800393, 32'h600);
    step();
    if_valid = 1'b0;
    chk("post_rst_instr", id_instr, 32'h00800393);
    chk("post_rst_pc", id_pc, 32'h600);
    step();

    // random handshakes against an ordered scoreboard
    seq = 32'h1000;
    for (int i = 0; i < 10000; i++) begin
      if_valid = 1'($urandom_range(0, 1));
      if_instr = $urandom;
      if_pc    = seq;
      id_ready = ($urandom_range(0, 3) != 0);
      #2;
      in_acc     = if_valid && if_ready;
      out_acc    = id_valid && id_ready;
      stall      = id_valid && !id_ready;
      hold_instr = id_instr;
      hold_pc    = id_pc;
      if (out_acc) begin
        if (sb.size() == 0) begin
          chk("rnd_unexpected_out", id_pc, 32'hFFFF_FFFF);
        end else begin
          exp_e = sb.pop_front();
          chk("rnd_pc", id_pc, exp_e[31:0]);
          chk("rnd_instr", id_instr, exp_e[63:32]);
        end
      end
      if (in_acc) begin
        sb.push_back({if_instr, if_pc});
        seq++;
      end
      step();
      if (stall) begin
        chk("rnd_stall_instr", id_instr, hold_instr);
        chk("rnd_stall_pc", id_pc, hold_pc);
      end
    end

    // drain remaining entries within a bounded number of cycles
    if_valid = 1'b0;
    id_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2;
      if (id_valid) begin
        if (sb.size() == 0) begin
          chk("drain_unexpected", id_pc, 32'hFFFF_FFFF);
        end else begin
          exp_e = sb.pop_front();
          chk("drain_pc", id_pc, exp_e[31:0]);
          chk("drain_instr", id_instr, exp_e[63:32]);
        end
      end
      step();
    end
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
